// File: rtl/booth_mult_seq.sv
// Radix-2 Booth sequential multiplier with a start/busy/done handshake and a registered product.
// Define BOOTH_MULT_UNSIGNED_EN to add the is_signed port for unsigned operation.
module booth_mult_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_MULT_UNSIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_MULT_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  // A carries one bit more than Q so that subtracting the most negative M cannot overflow.
  localparam int AW = QW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_a;
  logic [QW-1:0]       r_q;
  logic                r_qm1;
  logic [AW-1:0]       r_m;
  logic [CNT_W-1:0]    r_count;
  logic [2*WIDTH-1:0]  r_prod;
  logic                r_busy;
  logic                r_done;

  logic [AW-1:0]       w_sum;
  logic [AW+QW:0]      w_shift;
  logic [AW-1:0]       w_m_ext;
  logic [QW-1:0]       w_q_ext;
  logic [CNT_W-1:0]    w_cnt_init;
  logic [2*WIDTH-1:0]  w_prod;

`ifdef BOOTH_MULT_UNSIGNED_EN
  logic                r_sgn;

  assign w_m_ext    = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign w_q_ext    = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
  assign w_cnt_init = is_signed ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
  // Signed runs consume only WIDTH bits of the widened Q, leaving the product one bit higher.
  assign w_prod     = r_sgn ? {r_a[WIDTH-1:0], r_q[QW-1:1]} : {r_a[WIDTH-2:0], r_q};
`else
  assign w_m_ext    = {multiplicand[WIDTH-1], multiplicand};
  assign w_q_ext    = multiplier;
  assign w_cnt_init = CNT_W'(WIDTH);
  assign w_prod     = {r_a[WIDTH-1:0], r_q};
`endif

  assign w_shift = {w_sum[AW-1], w_sum, r_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Booth add/subtract selected by the recoded bit pair.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
      r_prod  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BOOTH_MULT_UNSIGNED_EN
      r_sgn   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= '0;
            r_q     <= w_q_ext;
            r_qm1   <= 1'b0;
            r_m     <= w_m_ext;
            r_count <= w_cnt_init;
            r_busy  <= 1'b1;
`ifdef BOOTH_MULT_UNSIGNED_EN
            r_sgn   <= is_signed;
`endif
          end
        end
        S_RUN: begin
          r_a     <= w_shift[AW+QW -: AW];
          r_q     <= w_shift[QW:1];
          r_qm1   <= w_shift[0];
          r_count <= r_count - CNT_W'(1);
        end
        S_DONE: begin
          r_prod <= w_prod;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: scoreboard of reference products popped on each done pulse.
module tb_booth_mult_seq;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef BOOTH_MULT_UNSIGNED_EN
  logic           is_signed;
`endif

  int             checks = 0;
  int             failures = 0;
  int             n_done = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
`ifdef BOOTH_MULT_UNSIGNED_EN
    .is_signed    (is_signed),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    longint x;
    longint y;
    longint p;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("product", 64'(product), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input int exp_lat, input string tag);
    int k;
    int nb;
    @(negedge clk);
    mc = a;
    mp = b;
    start = 1'b1;
`ifdef BOOTH_MULT_UNSIGNED_EN
    is_signed = sgn;
`endif
    exp_q.push_back(ref_mul(a, b, sgn));
    k = 0;
    nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      mc = W'($urandom);
      mp = W'($urandom);
      k++;
      if (busy === 1'b1) nb++;
    end while (done !== 1'b1 && k < 100);
    check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat - 1));
  endtask

  initial begin
    int k;
    int nd;
    logic [W-1:0] ha;
    logic [W-1:0] hb;
    logic [W-1:0] corners [6];

    rst_n = 1'b0;
    start = 1'b0;
    mc = '0;
    mp = '0;
`ifdef BOOTH_MULT_UNSIGNED_EN
    is_signed = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst_n = 1'b1;

    do_op(16'd3, 16'd5, 1'b1, W + 2, "t1");
    check("t1_value", 64'(product), 64'h0000_000F);

    do_op(16'hFFF9, 16'd3, 1'b1, W + 2, "t2a");
    check("t2a_value", 64'(product), 64'hFFFF_FFEB);
    do_op(16'h8000, 16'h8000, 1'b1, W + 2, "t2b");
    check("t2b_value", 64'(product), 64'h4000_0000);
    do_op(16'h7FFF, 16'h8000, 1'b1, W + 2, "t2c");
    check("t2c_value", 64'(product), 64'hC000_8000);

    // Start re-pulsed with other operands while busy must be ignored.
    @(negedge clk);
    mc = 16'd2;
    mp = 16'd2;
    start = 1'b1;
    exp_q.push_back(ref_mul(16'd2, 16'd2, 1'b1));
    nd = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      start = (i == 3 || i == 10);
      mc = 16'd9;
      mp = 16'd9;
    end
    start = 1'b0;
    check("t3_done_pulses", 64'(nd), 64'd1);
    check("t3_value", 64'(product), 64'h0000_0004);

    // Reset mid-operation clears outputs asynchronously.
    @(negedge clk);
    mc = 16'd100;
    mp = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_done", 64'(done), 64'd0);
    check("t4_rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd4, 16'hFFFC, 1'b1, W + 2, "t4");
    check("t4_value", 64'(product), 64'hFFFF_FFF0);

    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h8000;
    corners[3] = 16'h7FFF;
    corners[4] = 16'h0001;
    corners[5] = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        do_op(corners[i], corners[j], 1'b1, W + 2, "corner");
      end
    end
    for (int i = 0; i < 120; i++) begin
      do_op(W'($urandom), W'($urandom), 1'b1, W + 2, "rand");
    end

    // Start held high: one result every W+2 cycles.
    ha = 16'h1234;
    hb = 16'hFEDC;
    @(negedge clk);
    mc = ha;
    mp = hb;
    start = 1'b1;
    exp_q.push_back(ref_mul(ha, hb, 1'b1));
    for (int i = 0; i < 3; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done !== 1'b1 && k < 100);
      check("held_interval", 64'(k), 64'(W + 2));
      if (i < 2) exp_q.push_back(ref_mul(ha, hb, 1'b1));
      else start = 1'b0;
    end

`ifdef BOOTH_MULT_UNSIGNED_EN
    do_op(16'hFFFF, 16'hFFFF, 1'b0, W + 3, "t6u");
    check("t6u_value", 64'(product), 64'hFFFE_0001);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, W + 2, "t6s");
    check("t6s_value", 64'(product), 64'h0000_0001);
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'b0, W + 3, "rand_u");
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised radix-2 Booth sequential multiplier. It merges the datapath and control of the team's existing 16-bit Booth unit into one block with a start/busy/done handshake and a registered product. It sits behind the team's arithmetic dispatch logic. It performs one add/subtract-and-shift per clock.

Parameters:
WIDTH, 16, operand width in bits (>= 4); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
multiplicand  input  WIDTH  M operand, two's complement; sampled with start.
multiplier  input  WIDTH  Q operand, two's complement; sampled with start.
busy  output  1  high in RUN and DONE.
done  output  1  single-cycle pulse; product valid.
product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset: one clock, asynchronous and active-low (rst_n). Asserting rst_n low sets the FSM to IDLE and clears A, Q, q_m1, M, count, product, busy and done to 0. This applies immediately, including mid-operation; no partial result is exposed.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - A = 0, with A being WIDTH+1 bits, sign-extended. The extra bit prevents overflow when M = -2^(WIDTH-1).
  - Q = multiplier; q_m1 = 0.
  - M = multiplicand, sign-extended to WIDTH+1 bits.
  - count = WIDTH.
  - Next state RUN; busy = 1.
- RUN, each edge:
  - {Q[0],q_m1} = 10: A = A - M.
  - {Q[0],q_m1} = 01: A = A + M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by 1, replicating the A sign bit; count = count - 1.
  - When count = 1 at the edge, next state is DONE.
- DONE:
  - product = {A[WIDTH-1:0], Q}, registered; done = 1 for exactly one cycle; busy = 1.
  - Next edge: IDLE, done = 0, busy = 0.
- Latency: start sampled at E0, done high in the cycle after edge E0+WIDTH+1. Back-to-back starts allow one multiply every WIDTH+2 cycles.
- start while busy = 1: ignored; operands and state are unaffected.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Operand inputs are don't-care except at the accepting edge.
- Arithmetic is modulo 2^(WIDTH+1) inside A. The product is exact for every signed WIDTH x WIDTH pair, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).

Optional Feature:
Macro BOOTH_MULT_UNSIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled with start.
  - is_signed = 1: behaviour exactly as above.
  - is_signed = 0: multiplier and multiplicand are zero-extended to WIDTH+1 bits; Q and A widen by one bit (A becomes WIDTH+2 bits); count = WIDTH+1. done then arrives at E0+WIDTH+2.
  - product = low 2*WIDTH bits of the unsigned result.
- Not defined: no is_signed port; signed-only operation; no extra register bits.

Test Plan:
1. WIDTH=16, multiplicand=3, multiplier=5, pulse start -> done exactly 18 cycles after the start edge, product=0x0000000F, busy high for 17 cycles.
2. multiplicand=-7 (0xFFF9), multiplier=3 -> product=0xFFFFFFEB. Also multiplicand=0x8000, multiplier=0x8000 -> product=0x40000000. Also 0x7FFF x 0x8000 -> 0xC0008000.
3. Start accepted with 2 x 2, then start re-pulsed with 9 x 9 on cycles 3 and 10 while busy -> only product=0x00000004 is produced; exactly one done pulse.
4. rst_n low for one cycle, 8 cycles into a 100 x 100 operation -> busy, done and product are 0 immediately. A new start with 4 x -4 then gives 0xFFFFFFF0 with normal latency.
5. WIDTH=8 build: random signed sweep of 1000 pairs vs a reference model -> all match; done arrives 10 cycles after each accepted start; start held high yields one result every 10 cycles.
6. With BOOTH_MULT_UNSIGNED_EN, WIDTH=16, is_signed=0: 0xFFFF x 0xFFFF -> product=0xFFFE0001, done at 19 cycles. With is_signed=1, the same operands -> 0x00000001.
